// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM edge preconditioner: default sizes and FSM states.
package pwm_pkg;

  localparam int WIDTH_DEF = 13;
  localparam int DEPTH_DEF = 249;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } state_t;

endpackage

// File: rtl/pwm_calc_rise_fall.sv
// Per-channel edge arithmetic: clamps duty, folds phase into one period,
// splits the pulse around its centre and wraps both edges into [0, cycle).
module pwm_calc_rise_fall
  import pwm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IW    = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             issue_valid,
  input  logic [IW-1:0]    issue_idx,
  input  logic [WIDTH-1:0] cycle,
  input  logic [WIDTH-1:0] duty,
  input  logic [WIDTH-1:0] phase,
  output logic             wr_valid,
  output logic [IW-1:0]    wr_idx,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0]        d_s, lo_s, hi_s, p_s;
  logic                    v1_r, v2_r;
  logic [IW-1:0]           i1_r, i2_r;
  logic [WIDTH-1:0]        lo1_r, hi1_r, p1_r, c1_r, c2_r;
  logic signed [WIDTH:0]   r_s, r2_r;
  logic [WIDTH:0]          f_s, f2_r;

  // Stage 1 combinational: clamp duty, odd count goes to the falling half
  always_comb begin
    d_s  = (duty < cycle) ? duty : cycle;
    lo_s = d_s >> 1;
    hi_s = d_s - lo_s;
    p_s  = (phase >= cycle) ? (phase - cycle) : phase;
  end

  // Stage 1 register
  always_ff @(posedge CLK) begin
    if (RST) begin
      v1_r  <= 1'b0;
      i1_r  <= '0;
      lo1_r <= '0;
      hi1_r <= '0;
      p1_r  <= '0;
      c1_r  <= '0;
    end else begin
      v1_r  <= issue_valid;
      i1_r  <= issue_idx;
      lo1_r <= lo_s;
      hi1_r <= hi_s;
      p1_r  <= p_s;
      c1_r  <= cycle;
    end
  end

  // Stage 2 combinational: unwrapped edges, rise may go negative
  always_comb begin
    r_s = $signed({1'b0, p1_r}) - $signed({1'b0, lo1_r});
    f_s = {1'b0, p1_r} + {1'b0, hi1_r};
  end

  // Stage 2 register
  always_ff @(posedge CLK) begin
    if (RST) begin
      v2_r <= 1'b0;
      i2_r <= '0;
      r2_r <= '0;
      f2_r <= '0;
      c2_r <= '0;
    end else begin
      v2_r <= v1_r;
      i2_r <= i1_r;
      r2_r <= r_s;
      f2_r <= f_s;
      c2_r <= c1_r;
    end
  end

  // Stage 3: wrap into one period; true results fit WIDTH bits so modular math is exact
  always_comb begin
    rise = '0;
    fall = '0;
    if (c2_r == '0) begin
      rise = '0;
      fall = '0;
    end else begin
      if (r2_r[WIDTH]) begin
        rise = r2_r[WIDTH-1:0] + c2_r;
      end else begin
        rise = r2_r[WIDTH-1:0];
      end
      if (f2_r >= {1'b0, c2_r}) begin
        fall = f2_r[WIDTH-1:0] - c2_r;
      end else begin
        fall = f2_r[WIDTH-1:0];
      end
    end
  end

  assign wr_valid = v2_r;
  assign wr_idx   = i2_r;

endmodule

// File: rtl/pwm_preconditioner.sv
// Walks every channel through the edge pipeline into a shadow set, then
// publishes the whole set to RISE/FALL on a single edge.
module pwm_preconditioner
  import pwm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  input  logic [DEPTH*WIDTH-1:0] CYCLE,
  input  logic [DEPTH*WIDTH-1:0] DUTY,
  input  logic [DEPTH*WIDTH-1:0] PHASE,
  output logic [DEPTH*WIDTH-1:0] RISE,
  output logic [DEPTH*WIDTH-1:0] FALL,
  output logic                   BUSY,
  output logic                   DOUT_VALID
);

  localparam int            IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  state_t                 state_r, state_s;
  logic [IW-1:0]          idx_r;
  logic                   v0_r;
  logic [IW-1:0]          i0_r;
  logic [WIDTH-1:0]       c0_r, d0_r, p0_r;
  logic                   wr_valid_s;
  logic [IW-1:0]          wr_idx_s;
  logic [WIDTH-1:0]       wr_rise_s, wr_fall_s;
  logic [DEPTH*WIDTH-1:0] sh_rise_r, sh_fall_r, rise_r, fall_r;
  logic                   busy_r, dv_r;

  // Next-state logic; DRAIN ends on the cycle the last channel lands in the shadow
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (START) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (idx_r == LAST_IDX) state_s = DRAIN;
        else                   state_s = RUN;
      end
      DRAIN: begin
        if (wr_valid_s && (wr_idx_s == LAST_IDX)) state_s = COMMIT;
        else                                      state_s = DRAIN;
      end
      COMMIT:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register and channel index
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
      idx_r   <= '0;
    end else begin
      state_r <= state_s;
      if ((state_r == RUN) && (idx_r != LAST_IDX)) idx_r <= idx_r + 1'b1;
      else                                         idx_r <= '0;
    end
  end

  // Stage 0: capture the issued channel's inputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      v0_r <= 1'b0;
      i0_r <= '0;
      c0_r <= '0;
      d0_r <= '0;
      p0_r <= '0;
    end else begin
      v0_r <= (state_r == RUN);
      i0_r <= idx_r;
      c0_r <= CYCLE[int'(idx_r)*WIDTH +: WIDTH];
      d0_r <= DUTY[int'(idx_r)*WIDTH +: WIDTH];
      p0_r <= PHASE[int'(idx_r)*WIDTH +: WIDTH];
    end
  end

  pwm_calc_rise_fall #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_calc (
    .CLK         (CLK),
    .RST         (RST),
    .issue_valid (v0_r),
    .issue_idx   (i0_r),
    .cycle       (c0_r),
    .duty        (d0_r),
    .phase       (p0_r),
    .wr_valid    (wr_valid_s),
    .wr_idx      (wr_idx_s),
    .rise        (wr_rise_s),
    .fall        (wr_fall_s)
  );

  // Shadow set, filled one channel per cycle as results leave the pipeline
  always_ff @(posedge CLK) begin
    if (RST) begin
      sh_rise_r <= '0;
      sh_fall_r <= '0;
    end else if (wr_valid_s) begin
      sh_rise_r[int'(wr_idx_s)*WIDTH +: WIDTH] <= wr_rise_s;
      sh_fall_r[int'(wr_idx_s)*WIDTH +: WIDTH] <= wr_fall_s;
    end
  end

  // Published outputs; BUSY lags the FSM by one cycle so it starts after START is taken
  always_ff @(posedge CLK) begin
    if (RST) begin
      rise_r <= '0;
      fall_r <= '0;
      busy_r <= 1'b0;
      dv_r   <= 1'b0;
    end else begin
      busy_r <= (state_r == RUN) || (state_r == DRAIN);
      dv_r   <= (state_r == COMMIT);
      if (state_r == COMMIT) begin
        rise_r <= sh_rise_r;
        fall_r <= sh_fall_r;
      end
    end
  end

  assign RISE       = rise_r;
  assign FALL       = fall_r;
  assign BUSY       = busy_r;
  assign DOUT_VALID = dv_r;

endmodule

// File: doc/pwm_preconditioner.md
PWM_PRECONDITIONER -- requirements
Module: pwm_preconditioner

Interface
REQ-001 The module SHALL have parameter WIDTH, default 13, the bit width of every cycle, duty, phase and edge value.
REQ-002 The module SHALL have parameter DEPTH, default 249, the number of transducer channels.
REQ-003 The module SHALL have port CLK, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 The module SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port START, input, 1 bit: a one-cycle request to recompute all channels.
REQ-006 The module SHALL have port CYCLE, input, DEPTH x WIDTH: the per-channel PWM period in counts.
REQ-007 The module SHALL have port DUTY, input, DEPTH x WIDTH: the per-channel pulse width in counts.
REQ-008 The module SHALL have port PHASE, input, DEPTH x WIDTH: the per-channel pulse centre in counts.
REQ-009 The module SHALL have port RISE, output, DEPTH x WIDTH: the per-channel rising-edge time, fed to the PWM edge-latching buffer.
REQ-010 The module SHALL have port FALL, output, DEPTH x WIDTH: the per-channel falling-edge time, fed to the same buffer.
REQ-011 The module SHALL have port BUSY, output, 1 bit: high from the cycle after an accepted START until DOUT_VALID.
REQ-012 The module SHALL have port DOUT_VALID, output, 1 bit: a one-cycle pulse when RISE/FALL have just been updated.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, DRAIN and COMMIT; START is accepted only in IDLE and moves the FSM to RUN.
REQ-014 START asserted while BUSY SHALL be ignored, with no restart and no queuing.
REQ-015 In RUN, a channel index SHALL step 0..DEPTH-1, issuing one channel per cycle into a 4-stage pipeline, then move to DRAIN.
REQ-016 Stage 0 SHALL register the CYCLE, DUTY and PHASE values of the issued index.
REQ-017 Stage 1 SHALL form d = min(DUTY, CYCLE), lo = d>>1, hi = d-lo, and p = (PHASE >= CYCLE) ? PHASE-CYCLE : PHASE.
REQ-018 Stage 2 SHALL form r = p-lo and f = p+hi in WIDTH+1 bits, signed for r.
REQ-019 Stage 3 SHALL wrap the results (r<0 -> r+CYCLE; f>=CYCLE -> f-CYCLE) and write them to a shadow array at that index.
REQ-020 Channels with CYCLE=0 SHALL produce RISE=FALL=0.
REQ-021 In DRAIN, once the last index is written, the FSM SHALL move to COMMIT; in COMMIT, the shadow SHALL be copied to RISE/FALL on one edge, DOUT_VALID SHALL pulse, BUSY SHALL drop, and the FSM SHALL return to IDLE.
REQ-022 DOUT_VALID SHALL rise exactly DEPTH+4 cycles after the edge that sampled START, and RISE/FALL SHALL never show a partially updated set.
REQ-023 CYCLE, DUTY and PHASE SHALL be held stable by the source while BUSY; PHASE < 2*CYCLE is an input constraint.

Reset
REQ-024 On RST, the FSM SHALL go to IDLE, and RISE, FALL, the shadow array, the index, BUSY and DOUT_VALID SHALL all be cleared to 0.
REQ-025 RST mid-run SHALL abort the run with no DOUT_VALID, and the next START SHALL perform a full run.

Structure
REQ-026 WIDTH and DEPTH defaults and the FSM state enum SHALL live in the shared package pwm_pkg.
REQ-027 The per-channel arithmetic (stages 1-3) SHALL be a sub-module, pwm_calc_rise_fall, and the FSM, index and shadow logic SHALL stay in the top module.

Verification
REQ-028 CYCLE=4096, DUTY=2048, PHASE=1024 -> RISE=0, FALL=2048.
REQ-029 CYCLE=4096, DUTY=100, PHASE=0 -> RISE=4046, FALL=50 (wrap of r).
REQ-030 CYCLE=4096, DUTY=5000, PHASE=0 -> RISE=2048, FALL=2048 (clamp); and DUTY=3, PHASE=10 -> RISE=9, FALL=12 (odd split).
REQ-031 DUTY=0, PHASE=777 -> RISE=FALL=777; CYCLE=0 -> RISE=FALL=0.
REQ-032 START at cycle 0 and again at cycle 5 -> exactly one DOUT_VALID, at cycle DEPTH+4, and BUSY high cycles 1..DEPTH+3.
REQ-033 RST at cycle 100 of a run -> no DOUT_VALID and all outputs 0; a new START -> correct results at DEPTH+4 cycles later.
